// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing the USB FIFO-master write channel between NUM_CH packet sources.
// Optional macro USB_TX_HEADER_EN prepends a {A5C3, grant, seq} header word to each burst.
module usb_tx_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PACKET_SIZE = 1024,
  parameter int unsigned TXE_STABLE  = 3,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_CH-1:0]         ch_ready_in,
  output logic [NUM_CH-1:0]         ch_rd_en_out,
  input  logic [32*NUM_CH-1:0]      ch_data_in,
  input  logic [NUM_CH-1:0]         ch_valid_in,
  input  logic                      txe_n_in,
  output logic [31:0]               data_out,
  output logic [3:0]                be_out,
  output logic                      wr_n_out,
  output logic [$clog2(NUM_CH)-1:0] grant_out,
  output logic                      busy_out
);

  localparam int unsigned GW = $clog2(NUM_CH);
  localparam int unsigned WW = $clog2(PACKET_SIZE + 1);
  localparam int unsigned SW = $clog2(TXE_STABLE + 1);
  localparam int unsigned PW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StWaitTxe, StHeader, StBurst, StGap} state_e;

  state_e          state_q;
  logic [GW-1:0]   ptr_q;
  logic [SW-1:0]   txe_cnt_q;
  logic [WW-1:0]   word_cnt_q;
  logic [PW-1:0]   gap_cnt_q;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            pick_valid;
  logic [31:0]     ch_word [NUM_CH];
`ifdef USB_TX_HEADER_EN
  logic [7:0]      seq_q [NUM_CH];
`endif

  assign be_out = 4'hf;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_word
    assign ch_word[i] = ch_data_in[32*i +: 32];
  end

  // First ready source at or after the pointer, cyclically; lowest offset wins.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = GW'((32'(ptr_q) + 32'(k)) % NUM_CH);
      if (ch_ready_in[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      txe_cnt_q    <= '0;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      grant_out    <= '0;
      ch_rd_en_out <= '0;
      data_out     <= '0;
      wr_n_out     <= 1'b1;
      busy_out     <= 1'b0;
`ifdef USB_TX_HEADER_EN
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= 8'd0;
`endif
    end else begin
      data_out <= ch_word[grant_out];
      wr_n_out <= !(ch_valid_in[grant_out] && (state_q == StBurst || state_q == StGap));
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_out <= pick;
            txe_cnt_q <= '0;
            busy_out  <= 1'b1;
            state_q   <= StWaitTxe;
          end
        end
        StWaitTxe: begin
          if (txe_n_in) begin
            txe_cnt_q <= '0;
          end else if (txe_cnt_q == SW'(TXE_STABLE - 1)) begin
            txe_cnt_q  <= '0;
            word_cnt_q <= '0;
`ifdef USB_TX_HEADER_EN
            data_out   <= {16'hA5C3, 5'b0, 3'(grant_out), seq_q[grant_out]};
            wr_n_out   <= 1'b0;
            state_q    <= StHeader;
`else
            ch_rd_en_out <= NUM_CH'(1) << grant_out;
            state_q      <= StBurst;
`endif
          end else begin
            txe_cnt_q <= txe_cnt_q + 1'b1;
          end
        end
        StHeader: begin
          ch_rd_en_out <= NUM_CH'(1) << grant_out;
          state_q      <= StBurst;
        end
        StBurst: begin
          // txe_n is deliberately ignored: one burst fits the chip packet buffer.
          if (word_cnt_q == WW'(PACKET_SIZE - 1)) begin
            ch_rd_en_out <= '0;
            gap_cnt_q    <= '0;
            state_q      <= StGap;
`ifdef USB_TX_HEADER_EN
            seq_q[grant_out] <= seq_q[grant_out] + 8'd1;
`endif
          end else begin
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q == PW'(GAP_CYCLES - 1)) begin
            ptr_q    <= (grant_out == GW'(NUM_CH - 1)) ? '0 : grant_out + 1'b1;
            busy_out <= 1'b0;
            state_q  <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter with FIFO source models; builds with or without
// USB_TX_HEADER_EN.
module tb_usb_tx_arbiter;
  localparam int NCH = 4;
  localparam int PS  = 8;
  localparam int TS  = 3;
  localparam int GC  = 4;
`ifdef USB_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   ch_ready = '0;
  logic [NCH-1:0]   rd_en;
  logic [32*NCH-1:0] ch_data = '0;
  logic [NCH-1:0]   ch_valid = '0;
  logic             txe_n = 1'b1;
  logic [31:0]      data_out;
  logic [3:0]       be_out;
  logic             wr_n;
  logic [1:0]       grant;
  logic             busy;

  always #5 clk = ~clk;

  usb_tx_arbiter #(.NUM_CH(NCH), .PACKET_SIZE(PS), .TXE_STABLE(TS), .GAP_CYCLES(GC)) dut (
    .clk_in(clk), .rst_in(rst), .ch_ready_in(ch_ready), .ch_rd_en_out(rd_en),
    .ch_data_in(ch_data), .ch_valid_in(ch_valid), .txe_n_in(txe_n), .data_out(data_out),
    .be_out(be_out), .wr_n_out(wr_n), .grant_out(grant), .busy_out(busy)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];
  int          exp_grant[$];
  int          exp_cnt[NCH] = '{default: 0};
  int          src_cnt[NCH] = '{default: 0};
  logic [7:0]  seq_m[NCH]   = '{default: 8'd0};
  bit          quiet = 1'b1;
  bit          drop_en = 1'b0;
  int          drop_ch = 0;
  int          drop_at = 0;
  int          runlen = 0;
  logic [NCH-1:0] prev_rd = '0;
  int          rd_cyc = 0, fall_cyc = 0, last_lat = -1, last_space = -1;
  bit          lat_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFOs: data/valid one cycle after rd_en; optional single dropped word.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i] <= rd_en[i] && !(drop_en && drop_ch == i && src_cnt[i] == drop_at);
      ch_data[32*i +: 32] <= 32'(32'h1000_0000 * (i + 1) + src_cnt[i]);
      if (rd_en[i]) src_cnt[i] <= src_cnt[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (!quiet) begin
      if (wr_n === 1'b0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write data=%h with empty scoreboard", data_out);
        end else begin
          logic [31:0] ev;
          ev = exp_q.pop_front();
          vectors++;
          if (data_out !== ev) begin
            errors++;
            $display("FAIL bus_word got=%h want=%h", data_out, ev);
          end
        end
        if (lat_arm) begin
          last_lat = cyc - rd_cyc;
          lat_arm  = 1'b0;
        end
      end
      vectors++;
      if ($countones(rd_en) > 1) begin
        errors++;
        $display("FAIL rd_en_overlap got=%b want=at most one bit", rd_en);
      end
      if (rd_en != 0 && prev_rd == 0) begin
        rd_cyc     = cyc;
        lat_arm    = 1'b1;
        last_space = cyc - fall_cyc;
        if (exp_grant.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant rd_en=%b", rd_en);
        end else begin
          int g;
          g = exp_grant.pop_front();
          vectors++;
          if (rd_en !== NCH'(1 << g)) begin
            errors++;
            $display("FAIL grant_order got=%b want=%b", rd_en, NCH'(1 << g));
          end
        end
      end
      if (rd_en == 0 && prev_rd != 0) begin
        fall_cyc = cyc;
        vectors++;
        if (runlen != PS) begin
          errors++;
          $display("FAIL burst_length got=%0d want=%0d", runlen, PS);
        end
      end
    end
    runlen  = (rd_en != 0) ? runlen + 1 : 0;
    prev_rd = rd_en;
  end

  task automatic push_burst(input int ch, input int skip);
`ifdef USB_TX_HEADER_EN
    exp_q.push_back({16'hA5C3, 5'b0, 3'(ch), seq_m[ch]});
    seq_m[ch]++;
`endif
    push_data(ch, skip);
  endtask

  task automatic push_data(input int ch, input int skip);
    for (int k = 0; k < PS; k++)
      if (k != skip) exp_q.push_back(32'(32'h1000_0000 * (ch + 1) + exp_cnt[ch] + k));
    exp_cnt[ch] += PS;
    exp_grant.push_back(ch);
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== level) begin
      errors++;
      vectors++;
      $display("FAIL %s timeout busy=%b want=%b", name, busy, level);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0 || exp_grant.size() != 0) begin
      errors++;
      $display("FAIL %s_drained words_left=%0d grants_left=%0d want=0", name, exp_q.size(),
               exp_grant.size());
    end
  endtask

  task automatic run_flow(input int ch, input string name);
    ch_ready = NCH'(1 << ch);
    wait_busy(1'b1, 50, name);
    ch_ready = '0;
    vectors++;
    if (grant !== 2'(ch)) begin
      errors++;
      $display("FAIL %s_grant got=%0d want=%0d", name, grant, ch);
    end
    wait_busy(1'b0, 200, name);
    check_drained(name);
  endtask

  task automatic run_until_grants_done(input logic [NCH-1:0] ready, input string name);
    int n = 0;
    ch_ready = ready;
    while (exp_grant.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_grant.size() != 0) begin
      errors++;
      vectors++;
      $display("FAIL %s grant timeout left=%0d want=0", name, exp_grant.size());
    end
    ch_ready = '0;
    wait_busy(1'b0, 200, name);
    check_drained(name);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) seq_m[i] = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({wr_n, rd_en, busy, grant} !== {1'b1, 4'b0, 1'b0, 2'd0} || data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state wr_n=%b rd_en=%b busy=%b grant=%0d data=%h want 1/0/0/0/0",
               wr_n, rd_en, busy, grant, data_out);
    end
    vectors++;
    if (be_out !== 4'hf) begin
      errors++;
      $display("FAIL be_out got=%h want=f", be_out);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if ({wr_n, rd_en, busy} !== {1'b1, 4'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_quiet wr_n=%b rd_en=%b busy=%b want 1/0/0", wr_n, rd_en, busy);
      end
    end
  endtask

  task automatic test_single_burst();
    txe_n = 1'b0;
    push_burst(1, -1);
    run_flow(1, "single");
    vectors++;
    if (last_lat != 2) begin
      errors++;
      $display("FAIL rd_to_wr_latency got=%0d want=2", last_lat);
    end
  endtask

  task automatic test_back_to_back();
    push_burst(1, -1);
    push_burst(1, -1);
    run_until_grants_done(4'b0010, "back_to_back");
    vectors++;
    if (last_space < GC + 1 + TS) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d want>=%0d", last_space, GC + 1 + TS);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    push_burst(0, -1);
    push_burst(1, -1);
    push_burst(2, -1);
    push_burst(3, -1);
    push_burst(0, -1);
    run_until_grants_done(4'b1111, "round_robin");
  endtask

  task automatic test_debounce();
    int pat[7] = '{0, 0, 1, 0, 0, 0, 0};
    txe_n = 1'b1;
    push_burst(2, -1);
    ch_ready = 4'b0100;
    wait_busy(1'b1, 50, "debounce");
    ch_ready = '0;
    for (int k = 0; k < 7; k++) begin
      txe_n = pat[k][0];
      @(negedge clk);
      vectors++;
      if (rd_en[2] !== (k >= 5 + HDR)) begin
        errors++;
        $display("FAIL debounce_step%0d rd_en=%b want=%b", k, rd_en[2], (k >= 5 + HDR));
      end
    end
    txe_n = 1'b1;
    wait_busy(1'b0, 200, "debounce");
    check_drained("debounce");
    txe_n = 1'b0;
  endtask

  task automatic test_underrun();
    drop_en = 1'b1;
    drop_ch = 3;
    drop_at = exp_cnt[3] + 3;
    push_burst(3, 3);
    run_flow(3, "underrun");
    drop_en = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int t = 0;
    quiet = 1'b1;
    ch_ready = 4'b0100;
    wait_busy(1'b1, 50, "mid_reset");
    ch_ready = '0;
    while (n < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (rd_en[2]) n++;
    end
    vectors++;
    if (n != 4) begin
      errors++;
      $display("FAIL mid_reset_strobes got=%0d want=4", n);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd_en, wr_n, grant, busy} !== {4'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state rd_en=%b wr_n=%b grant=%0d busy=%b want 0/1/0/0",
               rd_en, wr_n, grant, busy);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (wr_n !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_discard wr_n=%b busy=%b want 1/0", wr_n, busy);
      end
    end
    exp_q.delete();
    exp_grant.delete();
    for (int i = 0; i < NCH; i++) begin
      exp_cnt[i] = src_cnt[i];
      seq_m[i]   = 8'd0;
    end
    quiet = 1'b0;
  endtask

`ifdef USB_TX_HEADER_EN
  task automatic test_header();
    apply_reset();
    push_burst(2, -1);
    run_flow(2, "header1");
    push_burst(2, -1);
    run_flow(2, "header2");
    exp_q.push_back(32'hA5C3_0202);
    seq_m[2]++;
    push_data(2, -1);
    run_flow(2, "header3");
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_round_robin();
    test_debounce();
    test_underrun();
    test_reset_mid_burst();
    push_burst(1, -1);
    run_flow(1, "after_reset");
`ifdef USB_TX_HEADER_EN
    test_header();
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
